// File: rtl/truth_scan_pkg.sv
// Shared definitions for the truth-table scanner: FSM encoding and widths.
package truth_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int INDEX_W     = 3;
  localparam int ERR_W       = 4;
  localparam int SETTLE_W    = 4;

  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0]   ERR_MAX    = ERR_W'(NUM_VECTORS);

endpackage

// File: rtl/scan_settle_timer.sv
// Settle countdown: load a hold length, count down to zero, then rest at zero.
module scan_settle_timer
  import truth_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - SETTLE_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks {A,B,C} through all 8 vectors, samples X after each settle window,
// and records the captured truth table plus mismatches against EXPECT.
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic [NUM_VECTORS-1:0] EXPECT,
  input  logic                   X,
  output logic                   A,
  output logic                   B,
  output logic                   C,
  output logic [NUM_VECTORS-1:0] TT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [ERR_W-1:0]       ERR_COUNT,
  output logic                   MISMATCH
);

  localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

  state_t                   state;
  logic [INDEX_W-1:0]       index;
  logic [INDEX_W-1:0]       vec;
  logic [NUM_VECTORS-1:0]   exp_l;
  logic                     load;
  logic                     zero;

  // START is a request qualified only by IDLE: while BUSY is high it is
  // neither accepted nor remembered, so a held START restarts after FINISH.
  assign load = ((state == IDLE) && START) ||
                ((state == HOLD) && zero && (index != LAST_INDEX));

  scan_settle_timer u_timer (
    .clk   (CLK),
    .rst_n (RST_N),
    .load  (load),
    .value (SETTLE_V),
    .zero  (zero)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      index     <= '0;
      vec       <= '0;
      exp_l     <= '0;
      TT        <= '0;
      ERR_COUNT <= '0;
      MISMATCH  <= 1'b0;
      DONE      <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            state     <= HOLD;
            BUSY      <= 1'b1;
            index     <= '0;
            vec       <= '0;
            exp_l     <= EXPECT;
            TT        <= '0;
            ERR_COUNT <= '0;
            MISMATCH  <= 1'b0;
          end
        end
        HOLD: begin
          if (zero) begin
            TT[index] <= X;
            if ((X != exp_l[index]) && (ERR_COUNT != ERR_MAX)) begin
              ERR_COUNT <= ERR_COUNT + ERR_W'(1);
              MISMATCH  <= 1'b1;
            end
            // The index stops at the last vector instead of wrapping.
            if (index != LAST_INDEX) begin
              index <= index + INDEX_W'(1);
              vec   <= index + INDEX_W'(1);
            end else begin
              state <= FINISH;
              vec   <= '0;
              DONE  <= 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  assign {A, B, C} = vec;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (SETTLE 1, 0, 2) checked every
// cycle against an elapsed-cycle model, plus directed literal expectations.
module tb_truth_table_scanner;

  localparam int SET_M[3] = '{1, 0, 2};

  // ---------------- clock / reset / stimulus signals ----------------
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] exp_v;
  logic       x_mode;
  logic       compare_en;

  logic [2:0] a_s, b_s, c_s, x_s, busy_s, done_s, mis_s;
  logic [7:0] tt_s[3];
  logic [3:0] err_s[3];

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage under test: A|C normally, constant 1 when x_mode is set.
  assign x_s = {3{x_mode}} | a_s | c_s;

  truth_table_scanner #(.SETTLE(1)) dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start), .EXPECT(exp_v), .X(x_s[0]),
    .A(a_s[0]), .B(b_s[0]), .C(c_s[0]), .TT(tt_s[0]), .BUSY(busy_s[0]),
    .DONE(done_s[0]), .ERR_COUNT(err_s[0]), .MISMATCH(mis_s[0]));

  truth_table_scanner #(.SETTLE(0)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start), .EXPECT(exp_v), .X(x_s[1]),
    .A(a_s[1]), .B(b_s[1]), .C(c_s[1]), .TT(tt_s[1]), .BUSY(busy_s[1]),
    .DONE(done_s[1]), .ERR_COUNT(err_s[1]), .MISMATCH(mis_s[1]));

  truth_table_scanner #(.SETTLE(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start), .EXPECT(exp_v), .X(x_s[2]),
    .A(a_s[2]), .B(b_s[2]), .C(c_s[2]), .TT(tt_s[2]), .BUSY(busy_s[2]),
    .DONE(done_s[2]), .ERR_COUNT(err_s[2]), .MISMATCH(mis_s[2]));

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] abc(input int d);
    return {a_s[d], b_s[d], c_s[d]};
  endfunction

  // ---------------- behavioural model ----------------
  function automatic bit stage(input bit xm, input int idx);
    logic [2:0] v;
    v = idx[2:0];
    return xm ? 1'b1 : (v[2] | v[0]);
  endfunction

  function automatic logic [7:0] tt_upto(input bit xm, input int n);
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < n; i++) t[i] = stage(xm, i);
    return t;
  endfunction

  function automatic logic [3:0] err_upto(input bit xm, input logic [7:0] e, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) if (stage(xm, i) != e[i]) cnt++;
    return 4'(cnt);
  endfunction

  // Each scan is described by the number of edges since START was accepted.
  bit         act_m[3];
  int         k_m[3];
  logic [7:0] exp_m[3];
  bit         xm_m[3];
  logic [7:0] fin_tt[3];
  logic [3:0] fin_err[3];

  initial begin
    for (int d = 0; d < 3; d++) begin
      act_m[d] = 0; k_m[d] = 0; exp_m[d] = '0; xm_m[d] = 0;
      fin_tt[d] = '0; fin_err[d] = '0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        act_m[d] = 0; k_m[d] = 0; fin_tt[d] = '0; fin_err[d] = '0;
      end else if (act_m[d]) begin
        k_m[d] = k_m[d] + 1;
        if (k_m[d] > 8 * (SET_M[d] + 1)) begin
          act_m[d]   = 0;
          fin_tt[d]  = tt_upto(xm_m[d], 8);
          fin_err[d] = err_upto(xm_m[d], exp_m[d], 8);
        end
      end else if (start) begin
        act_m[d] = 1; k_m[d] = 0; exp_m[d] = exp_v; xm_m[d] = x_mode;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (compare_en) begin
      for (int d = 0; d < 3; d++) begin
        int         w, s;
        logic [2:0] e_abc;
        logic [7:0] e_tt;
        logic [3:0] e_err;
        logic       e_busy, e_done;
        w = SET_M[d] + 1;
        if (act_m[d] && k_m[d] < 8 * w) begin
          s      = k_m[d] / w;
          e_abc  = 3'(s);
          e_busy = 1'b1;
          e_done = 1'b0;
          e_tt   = tt_upto(xm_m[d], s);
          e_err  = err_upto(xm_m[d], exp_m[d], s);
        end else if (act_m[d]) begin
          e_abc  = 3'd0;
          e_busy = 1'b1;
          e_done = 1'b1;
          e_tt   = tt_upto(xm_m[d], 8);
          e_err  = err_upto(xm_m[d], exp_m[d], 8);
        end else begin
          e_abc  = 3'd0;
          e_busy = 1'b0;
          e_done = 1'b0;
          e_tt   = fin_tt[d];
          e_err  = fin_err[d];
        end
        check($sformatf("cyc d%0d abc", d), abc(d), e_abc);
        check($sformatf("cyc d%0d tt", d), tt_s[d], e_tt);
        check($sformatf("cyc d%0d err", d), err_s[d], e_err);
        check($sformatf("cyc d%0d mismatch", d), mis_s[d], e_err != 0);
        check($sformatf("cyc d%0d busy", d), busy_s[d], e_busy);
        check($sformatf("cyc d%0d done", d), done_s[d], e_done);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [7:0] e);
    @(posedge clk);
    #1 exp_v = e; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the accepting edge; 0 means DONE never came.
  task automatic wait_done(input int d, input int lim, output int n);
    n = 0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (done_s[d]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n, pulses;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; exp_v = '0; x_mode = 1'b0; compare_en = 1'b0;
    idle(2);
    #1 compare_en = 1'b1;
    @(negedge clk);
    check("reset tt", tt_s[0], 8'h00);
    check("reset busy", busy_s[0], 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // V1: X=A|C, EXPECT matches
    pulse_start(8'hFA);
    wait_done(0, 40, n);
    check("v1 done edge", n, 17);
    check("v1 tt", tt_s[0], 8'hFA);
    check("v1 err", err_s[0], 4'd0);
    check("v1 mismatch", mis_s[0], 1'b0);
    idle(12);

    // V2: two differing vectors (1 and 3)
    pulse_start(8'hF0);
    wait_done(0, 40, n);
    check("v2 done edge", n, 17);
    check("v2 tt", tt_s[0], 8'hFA);
    check("v2 err", err_s[0], 4'd2);
    check("v2 mismatch", mis_s[0], 1'b1);
    idle(12);
    check("v2 hold tt", tt_s[0], 8'hFA);
    check("v2 hold err", err_s[0], 4'd2);

    // V3: SETTLE=0, X tied high, all eight vectors wrong
    #1 x_mode = 1'b1;
    pulse_start(8'h00);
    wait_done(1, 40, n);
    check("v3 done edge", n, 9);
    check("v3 tt", tt_s[1], 8'hFF);
    check("v3 err", err_s[1], 4'd8);
    check("v3 mismatch", mis_s[1], 1'b1);
    idle(30);
    #1 x_mode = 1'b0;

    // V4: reset just after edge 6 of a scan
    pulse_start(8'hFA);
    idle(6);
    #2 rst_n = 1'b0;
    #1;
    check("v4 abc", abc(0), 3'd0);
    check("v4 tt", tt_s[0], 8'h00);
    check("v4 err", err_s[0], 4'd0);
    check("v4 mismatch", mis_s[0], 1'b0);
    check("v4 busy", busy_s[0], 1'b0);
    check("v4 done", done_s[0], 1'b0);
    idle(3);
    #1 rst_n = 1'b1; exp_v = 8'hFA; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, 40, n);
    check("v4 rescan done edge", n, 17);
    check("v4 rescan tt", tt_s[0], 8'hFA);
    check("v4 rescan err", err_s[0], 4'd0);
    idle(12);

    // V5a: START re-pulsed at edges 3 and 10 is ignored
    pulse_start(8'hFA);
    idle(2);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    idle(6);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, 40, n);
    check("v5 done after edge 10", n, 7);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_s[0]) pulses++;
    end
    check("v5 extra done pulses", pulses, 0);
    idle(12);

    // V5b: START held high restarts on the first IDLE cycle after FINISH
    @(posedge clk);
    #1 exp_v = 8'hFA; start = 1'b1;
    @(posedge clk);
    wait_done(0, 40, n);
    check("v5 held done edge", n, 17);
    @(negedge clk);
    check("v5 idle gap busy", busy_s[0], 1'b0);
    @(negedge clk);
    check("v5 restart busy", busy_s[0], 1'b1);
    check("v5 restart tt", tt_s[0], 8'h00);
    @(posedge clk);
    #1 start = 1'b0;
    idle(40);

    // V6: SETTLE=2 vector sequence, 3 cycles per vector, then 000
    pulse_start(8'hFA);
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      check($sformatf("v6 abc n%0d", i), abc(2), (i <= 24) ? 3'((i - 1) / 3) : 3'd0);
    end
    check("v6 done", done_s[2], 1'b1);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
